seq_divider: RTL and testbench

Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group. Where the ripple-carry adder builds a sum in one pass, this block runs the inverse: one trial subtraction per cycle, one quotient bit per iteration, until the division is complete. It sits beside the ALU in the execute stage. It is started by a one-cycle `start` pulse and signals completion with a one-cycle `done` pulse. The core stalls while `busy` is high.

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It runs one trial subtraction per cycle and produces one quotient bit per cycle.
// After the N iterations, one cycle applies the sign correction and selects the result.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request pulse, taken only when no division is in flight
//   op        funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  rs1, sampled on an accepted start
//   divisor   rs2, sampled on an accepted start
//   busy      high while a division is in progress
//   done      one-cycle pulse, result valid in that cycle
//   result    quotient (DIV/DIVU) or remainder (REM/REMU), held until rewritten
//
// Optional build macro SEQ_DIV_FAST_SPECIAL_EN.
// It finishes divide-by-zero and signed overflow in one cycle.
// The results are the same with or without it; only the latency changes.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring iteration per cycle, cnt counts N-1 down to 0
// FIX   | sign correction and result select
// DONE  | done pulse; a new start may be accepted when busy is low

module seq_divider #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int CW = $clog2(N);
   localparam logic [N-1:0] ONES = {N{1'b1}};
   localparam logic [N-1:0] MIN  = {1'b1, {(N-1){1'b0}}};

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [N:0]     rem;
   logic [N-1:0]   quo;
   logic [N-1:0]   dvs;
   logic [1:0]     op_q;
   logic           neg_a;
   logic           neg_b;
   logic           dvs_zero;

   logic           is_signed;
   logic           accept;
   logic [N-1:0]   a_abs;
   logic [N-1:0]   b_abs;
   logic [N:0]     rem_sh;
   logic [N:0]     trial;
   logic [N-1:0]   q_fix;
   logic [N-1:0]   r_fix;

   always_comb begin
      is_signed = ~op[0];
      accept    = start && !busy && (state == IDLE || state == DONE);
      a_abs     = (is_signed && dividend[N-1]) ? -dividend : dividend;
      b_abs     = (is_signed && divisor[N-1])  ? -divisor  : divisor;
      // The quotient register holds the remaining dividend bits in its upper end.
      // Each iteration shifts a quotient bit in at the bottom.
      rem_sh    = {rem[N-1:0], quo[N-1]};
      trial     = rem_sh - {1'b0, dvs};
      // Do not negate on divide-by-zero, so a signed DIV by zero still gives all ones.
      q_fix     = (!op_q[0] && (neg_a != neg_b) && !dvs_zero) ? -quo : quo;
      r_fix     = (!op_q[0] && neg_a) ? -rem[N-1:0] : rem[N-1:0];
   end

`ifdef SEQ_DIV_FAST_SPECIAL_EN
   logic           special;
   logic [N-1:0]   special_res;

   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (divisor == '0) begin
         special     = 1'b1;
         special_res = op[1] ? dividend : ONES;
      end else if (is_signed && dividend == MIN && divisor == ONES) begin
         special     = 1'b1;
         special_res = op[1] ? '0 : MIN;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         op_q     <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         dvs_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (accept) begin
                  op_q     <= op;
                  neg_a    <= is_signed & dividend[N-1];
                  neg_b    <= is_signed & divisor[N-1];
                  dvs_zero <= (divisor == '0);
                  quo      <= a_abs;
                  dvs      <= b_abs;
                  rem      <= '0;
                  cnt      <= CW'(N - 1);
                  busy     <= 1'b1;
                  state    <= CALC;
`ifdef SEQ_DIV_FAST_SPECIAL_EN
                  if (special) begin
                     result <= special_res;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
`endif
               end
            end
            CALC: begin
               if (!trial[N]) begin
                  rem <= trial;
                  quo <= {quo[N-2:0], 1'b1};
               end else begin
                  rem <= rem_sh;
                  quo <= {quo[N-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               result <= op_q[1] ? r_fix : q_fix;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider at N=32.
// Each scenario task drives its stimulus and compares against hand-computed values.

module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

`ifdef SEQ_DIV_FAST_SPECIAL_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 34;
`endif

   seq_divider #(.N(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Launch one operation and return the result and the number of edges it took.
   // The sampling edge counts as edge 1.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      op = o; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] r; int lat;
      run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
      checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", r, 32'd14); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL divu_latency got=%0d exp=34", lat); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done got=%b exp=0", busy); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (result !== 32'd14) begin failures++; $display("FAIL result_hold got=%h exp=%h", result, 32'd14); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_single_pulse got=%b exp=0", done); end
      run_op(OP_REMU, 32'd100, 32'd7, r, lat);
      checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%h exp=2", r); end
   endtask

   task automatic test_signed();
      logic [31:0] r; int lat;
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, r, lat);
      checks++; if (r !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=FFFFFFFD", r); end
      run_op(OP_REM, 32'hFFFFFFF9, 32'd2, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_m7_2 got=%h exp=FFFFFFFF", r); end
      run_op(OP_DIV, 32'd20, 32'hFFFFFFFD, r, lat);
      checks++; if (r !== 32'hFFFFFFFA) begin failures++; $display("FAIL div_20_m3 got=%h exp=FFFFFFFA", r); end
      run_op(OP_REM, 32'd20, 32'hFFFFFFFD, r, lat);
      checks++; if (r !== 32'd2) begin failures++; $display("FAIL rem_20_m3 got=%h exp=2", r); end
      run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, r, lat);
      checks++; if (r !== 32'h7FFFFFFC) begin failures++; $display("FAIL divu_big_2 got=%h exp=7FFFFFFC", r); end
   endtask

   task automatic test_div_zero();
      logic [31:0] r; int lat;
      run_op(OP_DIVU, 32'd5, 32'd0, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_5_0 got=%h exp=FFFFFFFF", r); end
      checks++; if (lat !== SPECIAL_LAT) begin failures++; $display("FAIL div0_latency got=%0d exp=%0d", lat, SPECIAL_LAT); end
      run_op(OP_REM, 32'd5, 32'd0, r, lat);
      checks++; if (r !== 32'd5) begin failures++; $display("FAIL rem_5_0 got=%h exp=5", r); end
      run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_m5_0 got=%h exp=FFFFFFFF", r); end
      run_op(OP_REM, 32'hFFFFFFFB, 32'd0, r, lat);
      checks++; if (r !== 32'hFFFFFFFB) begin failures++; $display("FAIL rem_m5_0 got=%h exp=FFFFFFFB", r); end
   endtask

   task automatic test_overflow();
      logic [31:0] r; int lat;
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", r); end
      checks++; if (lat !== SPECIAL_LAT) begin failures++; $display("FAIL ovf_latency got=%0d exp=%0d", lat, SPECIAL_LAT); end
      run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=0", r); end
   endtask

   task automatic test_start_while_busy();
      int lat;
      @(negedge clk);
      op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", busy); end
      repeat (9) begin @(posedge clk); #1; lat++; end
      op = OP_REM; dividend = 32'd77; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      lat++;
      start = 1'b0; dividend = 32'd12345; divisor = 32'd9;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++; if (result !== 32'd100) begin failures++; $display("FAIL start_busy_result got=%h exp=%h", result, 32'd100); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL start_busy_latency got=%0d exp=34", lat); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", result); end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done) seen++; end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", seen); end
      // A reset and a start in the same cycle: the reset wins.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_start_same got=%0d exp=0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int lat;
      run_op(OP_DIVU, 32'd81, 32'd9, r, lat);
      checks++; if (r !== 32'd9) begin failures++; $display("FAIL b2b_first got=%h exp=9", r); end
      // A start driven in the done cycle is sampled on the edge that ends DONE.
      op = OP_REMU; dividend = 32'd1001; divisor = 32'd13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL b2b_second got=%h exp=0", result); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_spacing got=%0d exp=34", lat); end
      run_op(OP_REMU, 32'd1000, 32'd13, r, lat);
      checks++; if (r !== 32'd12) begin failures++; $display("FAIL remu_1000_13 got=%h exp=12", r); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
